// File: rtl/ball_pkg.sv
// Shared encodings and screen defaults for the ball motion block.
package ball_pkg;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    localparam int DEF_X_RES = 1024;
    localparam int DEF_Y_RES = 768;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_MISS = 2'd2
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// Motion prescaler: one-cycle o_tick every TICK_DIV cycles of i_run; i_reload restarts the interval.
module tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic pclk,
    input  logic reset,
    input  logic i_run,
    input  logic i_reload,
    output logic o_tick
);
    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LOAD = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = i_run && (r_cnt == '0);

    always_ff @(posedge pclk) begin
        if (reset || i_reload) begin
            r_cnt <= LOAD;
        end else if (i_run) begin
            r_cnt <= (r_cnt == '0) ? LOAD : r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/ball_motion_xy.sv
// 2-D ball motion: steps the centre once per tick, bounces off top/bottom, reflects on
// collision flags, and pulses a miss when the ball clamps against the left or right wall.
module ball_motion_xy
    import ball_pkg::*;
#(
    parameter int W        = 12,
    parameter int X_RES    = DEF_X_RES,
    parameter int Y_RES    = DEF_Y_RES,
    parameter int BALL_R   = 10,
    parameter int TICK_DIV = 1_000_000,
    parameter int STEP_MAX = 4,
    parameter int X_START  = 512,
    parameter int Y_START  = 30
) (
    input  logic         pclk,
    input  logic         reset,
    input  logic         i_enable,
    input  logic         i_serve,
    input  logic         i_serve_dir,
    input  logic         i_coll_x,
    input  logic         i_coll_y,
    output logic [W-1:0] o_x_pos,
    output logic [W-1:0] o_y_pos,
    output logic         o_moving,
    output logic         o_miss_l,
    output logic         o_miss_r
);
    localparam logic [W-1:0] X_LO   = W'(BALL_R);
    localparam logic [W-1:0] X_HI   = W'(X_RES - 1 - BALL_R);
    localparam logic [W-1:0] Y_LO   = W'(BALL_R);
    localparam logic [W-1:0] Y_HI   = W'(Y_RES - 1 - BALL_R);
    localparam logic [W-1:0] X_INIT = W'(X_START);
    localparam logic [W-1:0] Y_INIT = W'(Y_START);
    localparam logic [W-1:0] S_MAX  = W'(STEP_MAX);

    // Returns {wall_hit, new_pos}; DIR_DOWN and DIR_RIGHT share the incrementing encoding.
    function automatic logic [W:0] axis_move(input logic [W-1:0] pos, input logic [W-1:0] stp,
                                             input logic dir, input logic [W-1:0] lo,
                                             input logic [W-1:0] hi);
        if (dir == DIR_DOWN) begin
            if (({1'b0, pos} + {1'b0, stp}) >= {1'b0, hi}) return {1'b1, hi};
            return {1'b0, pos + stp};
        end
        if ({1'b0, pos} <= ({1'b0, lo} + {1'b0, stp})) return {1'b1, lo};
        return {1'b0, pos - stp};
    endfunction

    state_t       r_state, w_state_nxt;
    logic [W-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
    logic [W-1:0] r_step, w_step_nxt, w_step_use;
    logic         r_dir_x, r_dir_y, w_dir_x_nxt, w_dir_y_nxt;
    logic         r_pend_x, r_pend_y, w_pend_x_nxt, w_pend_y_nxt;
    logic         r_moving, r_miss_l, r_miss_r, w_miss_l_nxt, w_miss_r_nxt;
    logic         w_run, w_reload, w_tick, w_px, w_py, w_dx_alt, w_dy_alt;
    logic [W:0]   w_x_orig, w_x_alt, w_y_orig, w_y_alt;

    assign w_run    = i_enable && (r_state == ST_MOVE);
    assign w_reload = (r_state == ST_IDLE) && i_serve;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .pclk     (pclk),
        .reset    (reset),
        .i_run    (w_run),
        .i_reload (w_reload),
        .o_tick   (w_tick)
    );

    // A pulse on the tick cycle itself is consumed by that tick rather than lost.
    assign w_px       = r_pend_x | i_coll_x;
    assign w_py       = r_pend_y | i_coll_y;
    assign w_step_use = (w_px && (r_step < S_MAX)) ? r_step + 1'b1 : r_step;
    assign w_dx_alt   = r_dir_x ^ w_px;
    assign w_dy_alt   = r_dir_y ^ w_py;
    // Wall check in the original direction takes precedence over a pending reflection.
    assign w_x_orig   = axis_move(r_x, w_step_use, r_dir_x, X_LO, X_HI);
    assign w_x_alt    = axis_move(r_x, w_step_use, w_dx_alt, X_LO, X_HI);
    assign w_y_orig   = axis_move(r_y, w_step_use, r_dir_y, Y_LO, Y_HI);
    assign w_y_alt    = axis_move(r_y, w_step_use, w_dy_alt, Y_LO, Y_HI);

    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_step_nxt   = r_step;
        w_dir_x_nxt  = r_dir_x;
        w_dir_y_nxt  = r_dir_y;
        w_pend_x_nxt = r_pend_x;
        w_pend_y_nxt = r_pend_y;
        w_miss_l_nxt = 1'b0;
        w_miss_r_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_serve) begin
                    w_state_nxt = ST_MOVE;
                    w_dir_x_nxt = i_serve_dir ? DIR_LEFT : DIR_RIGHT;
                    w_step_nxt  = W'(1);
                end
            end
            ST_MOVE: begin
                if (i_enable && !w_tick) begin
                    w_pend_x_nxt = w_px;
                    w_pend_y_nxt = w_py;
                end else if (i_enable) begin
                    w_step_nxt   = w_step_use;
                    w_pend_x_nxt = 1'b0;
                    w_pend_y_nxt = 1'b0;
                    if (w_y_orig[W]) begin
                        w_y_nxt     = w_y_orig[W-1:0];
                        w_dir_y_nxt = (r_dir_y == DIR_DOWN) ? DIR_UP : DIR_DOWN;
                    end else begin
                        w_y_nxt     = w_y_alt[W-1:0];
                        w_dir_y_nxt = w_dy_alt ^ w_y_alt[W];
                    end
                    if (w_x_orig[W]) begin
                        w_x_nxt      = w_x_orig[W-1:0];
                        w_state_nxt  = ST_MISS;
                        w_miss_r_nxt = (r_dir_x == DIR_RIGHT);
                        w_miss_l_nxt = (r_dir_x == DIR_LEFT);
                    end else begin
                        w_x_nxt     = w_x_alt[W-1:0];
                        w_dir_x_nxt = w_dx_alt;
                        if (w_x_alt[W]) begin
                            w_state_nxt  = ST_MISS;
                            w_miss_r_nxt = (w_dx_alt == DIR_RIGHT);
                            w_miss_l_nxt = (w_dx_alt == DIR_LEFT);
                        end
                    end
                end
            end
            ST_MISS: begin
                w_state_nxt = ST_IDLE;
                w_x_nxt     = X_INIT;
                w_y_nxt     = Y_INIT;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_x      <= X_INIT;
            r_y      <= Y_INIT;
            r_step   <= W'(1);
            r_dir_x  <= DIR_RIGHT;
            r_dir_y  <= DIR_DOWN;
            r_pend_x <= 1'b0;
            r_pend_y <= 1'b0;
            r_moving <= 1'b0;
            r_miss_l <= 1'b0;
            r_miss_r <= 1'b0;
        end else begin
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_step   <= w_step_nxt;
            r_dir_x  <= w_dir_x_nxt;
            r_dir_y  <= w_dir_y_nxt;
            r_pend_x <= w_pend_x_nxt;
            r_pend_y <= w_pend_y_nxt;
            r_moving <= (w_state_nxt == ST_MOVE);
            r_miss_l <= w_miss_l_nxt;
            r_miss_r <= w_miss_r_nxt;
        end
    end

    assign o_x_pos  = r_x;
    assign o_y_pos  = r_y;
    assign o_moving = r_moving;
    assign o_miss_l = r_miss_l;
    assign o_miss_r = r_miss_r;

endmodule

// File: tb/tb_ball_motion_xy.sv
// Bench for ball_motion_xy: directed scenarios plus random play against a signed-integer game model.
module tb_ball_motion_xy;
    localparam int W = 12, X_RES = 64, Y_RES = 48, BALL_R = 2, TICK_DIV = 4, STEP_MAX = 3;
    localparam int X_START = 32, Y_START = 30;
    localparam int X_LO = BALL_R, X_HI = X_RES - 1 - BALL_R;
    localparam int Y_LO = BALL_R, Y_HI = Y_RES - 1 - BALL_R;

    logic         pclk = 1'b0;
    logic         reset = 1'b1, en = 1'b0, serve = 1'b0, sdir = 1'b0, cx = 1'b0, cy = 1'b0;
    logic [W-1:0] x_pos, y_pos;
    logic         moving, miss_l, miss_r;
    int           n_checks = 0, n_errors = 0;

    // Model: 0 idle, 1 moving, 2 miss; directions are +1 / -1 in screen coordinates.
    int m_st, m_x, m_y, m_dx, m_dy, m_step, m_cnt;
    bit m_px, m_py, m_moving, m_ml, m_mr;

    always #5 pclk = ~pclk;

    ball_motion_xy #(.W(W), .X_RES(X_RES), .Y_RES(Y_RES), .BALL_R(BALL_R), .TICK_DIV(TICK_DIV),
                     .STEP_MAX(STEP_MAX), .X_START(X_START), .Y_START(Y_START)) dut (
        .pclk(pclk), .reset(reset), .i_enable(en), .i_serve(serve), .i_serve_dir(sdir),
        .i_coll_x(cx), .i_coll_y(cy), .o_x_pos(x_pos), .o_y_pos(y_pos), .o_moving(moving),
        .o_miss_l(miss_l), .o_miss_r(miss_r));

    function automatic logic [2*W+2:0] exp_vec();
        logic [W-1:0] ex, ey;
        ex = m_x[W-1:0];
        ey = m_y[W-1:0];
        return {ex, ey, m_moving, m_ml, m_mr};
    endfunction

    function automatic logic [2*W+2:0] obs_vec();
        return {x_pos, y_pos, moving, miss_l, miss_r};
    endfunction

    // One axis on a tick: a wall reached in the current direction wins; otherwise a pending
    // hit reverses the direction and the move is taken that way.
    function automatic void axis(input int pos, input int d, input int s, input bit pend,
                                 input int lo, input int hi, output int npos, output int nd,
                                 output bit hit);
        int c, d2;
        c = pos + d * s;
        if ((d > 0) ? (c >= hi) : (c <= lo)) begin
            npos = (d > 0) ? hi : lo; nd = -d; hit = 1'b1;
        end else begin
            d2 = pend ? -d : d;
            c  = pos + d2 * s;
            if ((d2 > 0) ? (c >= hi) : (c <= lo)) begin
                npos = (d2 > 0) ? hi : lo; nd = -d2; hit = 1'b1;
            end else begin
                npos = c; nd = d2; hit = 1'b0;
            end
        end
    endfunction

    task automatic model_update(input bit rst, input bit e, input bit sv, input bit sd,
                                input bit ccx, input bit ccy);
        int nx, ny, ndx, ndy, s;
        bit hx, hy, px, py;
        m_ml = 1'b0;
        m_mr = 1'b0;
        if (rst) begin
            m_st = 0; m_x = X_START; m_y = Y_START; m_dx = 1; m_dy = 1;
            m_step = 1; m_cnt = TICK_DIV - 1; m_px = 1'b0; m_py = 1'b0;
        end else if (m_st == 0) begin
            if (sv) begin
                m_st = 1; m_dx = sd ? -1 : 1; m_step = 1; m_cnt = TICK_DIV - 1;
            end
        end else if (m_st == 1) begin
            if (e) begin
                px = m_px | ccx;
                py = m_py | ccy;
                if (m_cnt == 0) begin
                    m_cnt = TICK_DIV - 1;
                    s = px ? ((m_step + 1 > STEP_MAX) ? STEP_MAX : m_step + 1) : m_step;
                    m_step = s; m_px = 1'b0; m_py = 1'b0;
                    axis(m_y, m_dy, s, py, Y_LO, Y_HI, ny, ndy, hy);
                    m_y = ny; m_dy = ndy;
                    axis(m_x, m_dx, s, px, X_LO, X_HI, nx, ndx, hx);
                    m_x = nx; m_dx = ndx;
                    if (hx) begin
                        m_st = 2;
                        if (nx == X_HI) m_mr = 1'b1; else m_ml = 1'b1;
                    end
                end else begin
                    m_cnt = m_cnt - 1; m_px = px; m_py = py;
                end
            end
        end else begin
            m_st = 0; m_x = X_START; m_y = Y_START;
        end
        m_moving = (m_st == 1);
    endtask

    task automatic cyc(input bit rst, input bit e, input bit sv, input bit sd,
                       input bit ccx, input bit ccy);
        reset = rst; en = e; serve = sv; sdir = sd; cx = ccx; cy = ccy;
        model_update(rst, e, sv, sd, ccx, ccy);
        @(posedge pclk);
        #1;
    endtask

    // Runs until the model's y reaches the target while moving; returns 0 if the budget expires.
    task automatic run_to_y(input int target, output bit found);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc(0, 1, 0, 0, 0, 0);
            if (m_y == target && m_moving) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_errors++; $display("FAIL reset_vec: got %h expected %h", obs_vec(), exp_vec());
        end
        n_checks++;
        if (x_pos !== 12'd32 || y_pos !== 12'd30 || moving !== 1'b0 || miss_l !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_vals: got x=%0d y=%0d mv=%b ml=%b expected 32 30 0 0",
                     x_pos, y_pos, moving, miss_l);
        end
    endtask

    task automatic test_serve();
        cyc(0, 1, 1, 0, 0, 0);
        n_checks++;
        if (moving !== 1'b1) begin
            n_errors++; $display("FAIL serve_moving: got %b expected 1", moving);
        end
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, 0, 0, 0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++; $display("FAIL serve_vec[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (i == 4) begin
                n_checks++;
                if (x_pos !== 12'd33 || y_pos !== 12'd31) begin
                    n_errors++; $display("FAIL serve_tick1: got x=%0d y=%0d expected 33 31", x_pos, y_pos);
                end
            end
            if (i == 8) begin
                n_checks++;
                if (x_pos !== 12'd34) begin
                    n_errors++; $display("FAIL serve_tick2: got x=%0d expected 34", x_pos);
                end
            end
        end
    endtask

    task automatic test_bottom_wall();
        bit found;
        int ymax;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        run_to_y(44, found);
        n_checks++;
        if (!found || y_pos !== 12'd44) begin
            n_errors++; $display("FAIL wall_reach44: got y=%0d found=%b expected 44", y_pos, found);
        end
        ymax = 0;
        for (int i = 1; i <= 24; i++) begin
            cyc(0, 1, 0, 0, 0, 0);
            if (int'(y_pos) > ymax) ymax = int'(y_pos);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++; $display("FAIL wall_vec[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (i == 4 || i == 8) begin
                n_checks++;
                if (y_pos !== ((i == 4) ? 12'd45 : 12'd44)) begin
                    n_errors++; $display("FAIL wall_clamp[%0d]: got y=%0d expected %0d", i, y_pos, (i == 4) ? 45 : 44);
                end
            end
        end
        n_checks++;
        if (ymax > Y_HI) begin
            n_errors++; $display("FAIL wall_ymax: got %0d expected <= %0d", ymax, Y_HI);
        end
    endtask

    task automatic test_coll_x();
        int exp_x[3];
        exp_x = '{30, 33, 30};
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 1; i <= 4; i++) begin
                cyc(0, 1, 0, 0, (i == 2) || (k == 2 && i == 3), 0);
                n_checks++;
                if (obs_vec() !== exp_vec()) begin
                    n_errors++; $display("FAIL collx_vec[%0d.%0d]: got %h expected %h", k, i, obs_vec(), exp_vec());
                end
            end
            n_checks++;
            if (x_pos !== exp_x[k][W-1:0]) begin
                n_errors++; $display("FAIL collx_pos[%0d]: got x=%0d expected %0d", k, x_pos, exp_x[k]);
            end
        end
    endtask

    task automatic test_miss_left();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            cyc(0, 1, 0, 0, 0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++; $display("FAIL miss_vec[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (miss_l === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || x_pos !== 12'd2 || miss_r !== 1'b0) begin
            n_errors++; $display("FAIL miss_pulse: got seen=%b x=%0d mr=%b expected 1 2 0", seen, x_pos, miss_r);
        end
        cyc(0, 1, 0, 0, 0, 0);
        n_checks++;
        if (miss_l !== 1'b0 || x_pos !== 12'd32 || y_pos !== 12'd30 || moving !== 1'b0) begin
            n_errors++;
            $display("FAIL miss_after: got ml=%b x=%0d y=%0d mv=%b expected 0 32 30 0", miss_l, x_pos, y_pos, moving);
        end
    endtask

    task automatic test_enable_freeze();
        int hx, hy;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0, 0);
        hx = m_x;
        hy = m_y;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0, i == 5, i == 6);
            n_checks++;
            if (int'(x_pos) != hx || int'(y_pos) != hy || moving !== 1'b1) begin
                n_errors++; $display("FAIL freeze_hold[%0d]: got %0d,%0d expected %0d,%0d", i, x_pos, y_pos, hx, hy);
            end
        end
        for (int i = 0; i < 12; i++) begin
            cyc(0, 1, 0, 0, 0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++; $display("FAIL freeze_resume[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_coll_y_wall();
        bit found;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        run_to_y(44, found);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, 0, 0, 0, i == 2);
            if (i == 4 || i == 8) begin
                n_checks++;
                if (!found || y_pos !== ((i == 4) ? 12'd45 : 12'd44)) begin
                    n_errors++; $display("FAIL colly_wall[%0d]: got y=%0d expected %0d", i, y_pos, (i == 4) ? 45 : 44);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 37; i++) cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (x_pos !== 12'd32 || y_pos !== 12'd30 || moving !== 1'b0 || miss_l !== 1'b0 || miss_r !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_mid[%0d]: got x=%0d y=%0d mv=%b ml=%b mr=%b expected 32 30 0 0 0",
                         i, x_pos, y_pos, moving, miss_l, miss_r);
            end
            cyc(0, 1, 0, 0, 0, 0);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                1'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++;
                errs++;
                if (errs <= 10) $display("FAIL random_vec[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_bottom_wall();
        test_coll_x();
        test_miss_left();
        test_enable_freeze();
        test_coll_y_wall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
